// File: rtl/dma_mc_pkg.sv
// Shared definitions for the DMA memory-side controller: state encoding and
// default geometry, also used by core_control and the benches.
package dma_mc_pkg;

  localparam int DMA_DATA_W = 32;
  localparam int DMA_ADDR_W = 6;
  localparam int DMA_DEPTH  = 64;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FILL      = 3'd1;
  localparam logic [2:0] ST_STREAM    = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_ERR       = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    FILL      = ST_FILL,
    STREAM    = ST_STREAM,
    WAIT_DONE = ST_WAIT_DONE,
    DONE      = ST_DONE,
    ERR       = ST_ERR
  } mc_state_t;

endpackage

// File: rtl/mc_word_ram.sv
// Block buffer: DEPTH x DATA_W flop array, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module mc_word_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dma_mem_controller.sv
// Memory-side responder: fills a local buffer from sequential writes, streams it
// to the processing unit over valid/ready, then reports block completion.
module dma_mem_controller
  import dma_mc_pkg::*;
#(
  parameter int DATA_W = DMA_DATA_W,
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DEPTH  = DMA_DEPTH
) (
  input  logic              mc_clk,
  input  logic              mc_reset,
  input  logic [ADDR_W-1:0] mc_data_address_in,
  input  logic              mc_we,
  input  logic [DATA_W-1:0] mc_wdata,
  input  logic              mc_last,
  input  logic              mc_err_clr,
  output logic [DATA_W-1:0] procc_data,
  output logic              procc_valid,
  input  logic              procc_ready,
  input  logic              procc_done,
  output logic              mc_cont_procc,
  output logic              mc_data_done,
  output logic              mc_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  mc_state_t         state, state_next;
  logic [ADDR_W:0]   wr_cnt, wr_cnt_next;
  logic [ADDR_W:0]   rd_ptr, rd_ptr_next;
  logic              valid_next;
  logic [DATA_W-1:0] data_next;
  logic [DATA_W-1:0] rd_word;
  logic              ram_we;
  logic              wr_legal;
  logic              rd_avail;
  logic              accept;

  mc_word_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (mc_clk),
    .we    (ram_we),
    .waddr (mc_data_address_in),
    .wdata (mc_wdata),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_word)
  );

  // Writes must arrive strictly in order and never beyond the buffer.
  assign wr_legal = ({1'b0, mc_data_address_in} == wr_cnt) && (wr_cnt < DEPTH_C);
  assign rd_avail = rd_ptr < wr_cnt;
  assign accept   = procc_valid && procc_ready;

  always_ff @(posedge mc_clk or negedge mc_reset) begin
    if (!mc_reset) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_ptr      <= '0;
      procc_valid <= 1'b0;
      procc_data  <= '0;
    end else begin
      state       <= state_next;
      wr_cnt      <= wr_cnt_next;
      rd_ptr      <= rd_ptr_next;
      procc_valid <= valid_next;
      procc_data  <= data_next;
    end
  end

  always_comb begin
    state_next  = state;
    wr_cnt_next = wr_cnt;
    rd_ptr_next = rd_ptr;
    valid_next  = procc_valid;
    data_next   = procc_data;
    ram_we      = 1'b0;
    case (state)
      IDLE, FILL: begin
        if (state == FILL && procc_done) begin
          state_next = ERR;
        end else if (mc_we) begin
          if (wr_legal) begin
            ram_we      = 1'b1;
            wr_cnt_next = wr_cnt + 1'b1;
            state_next  = mc_last ? STREAM : FILL;
          end else begin
            state_next = ERR;
          end
        end
      end
      STREAM: begin
        if (mc_we || procc_done) begin
          state_next = ERR;
        end else begin
          // Output register refills whenever it is empty or being drained.
          if ((!procc_valid || procc_ready) && rd_avail) begin
            data_next   = rd_word;
            valid_next  = 1'b1;
            rd_ptr_next = rd_ptr + 1'b1;
          end else if (procc_ready) begin
            valid_next = 1'b0;
          end
          if (accept && rd_ptr == wr_cnt) state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        valid_next = 1'b0;
        if (mc_we)           state_next = ERR;
        else if (procc_done) state_next = DONE;
      end
      DONE: begin
        if (mc_we) begin
          state_next = ERR;
        end else begin
          state_next  = IDLE;
          wr_cnt_next = '0;
          rd_ptr_next = '0;
        end
      end
      ERR: begin
        if (mc_err_clr) begin
          state_next  = IDLE;
          wr_cnt_next = '0;
          rd_ptr_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next == ERR) valid_next = 1'b0;
  end

  assign mc_cont_procc = (state == STREAM) || (state == WAIT_DONE);
  assign mc_data_done  = (state == DONE);
  assign mc_err        = (state == ERR);

endmodule

// File: tb/tb_dma_mem_controller.sv
// Randomized scoreboard bench for dma_mem_controller: a block-level model predicts
// the stream and error flag; a monitor checks every accepted beat.
module tb_dma_mem_controller;
  import dma_mc_pkg::*;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DEP = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          we, last, err_clr, pready, pdone;
  logic [DW-1:0] wdata, pdata;
  logic          pvalid, cont, ddone, err;

  logic [AW-1:0] s_addr;
  logic          s_we, s_last, s_clr;
  logic [DW-1:0] s_wdata, s_pdata;
  logic          s_pvalid, s_cont, s_ddone, s_err;

  always #5 clk = ~clk;

  dma_mem_controller #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
    .mc_clk(clk), .mc_reset(rst_n), .mc_data_address_in(addr), .mc_we(we),
    .mc_wdata(wdata), .mc_last(last), .mc_err_clr(err_clr),
    .procc_data(pdata), .procc_valid(pvalid), .procc_ready(pready),
    .procc_done(pdone), .mc_cont_procc(cont), .mc_data_done(ddone), .mc_err(err)
  );

  dma_mem_controller #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4)) dut_small (
    .mc_clk(clk), .mc_reset(rst_n), .mc_data_address_in(s_addr), .mc_we(s_we),
    .mc_wdata(s_wdata), .mc_last(s_last), .mc_err_clr(s_clr),
    .procc_data(s_pdata), .procc_valid(s_pvalid), .procc_ready(1'b1),
    .procc_done(1'b0), .mc_cont_procc(s_cont), .mc_data_done(s_ddone), .mc_err(s_err)
  );

  int checks = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the block is just the ordered list of legally written words.
  logic [DW-1:0] sb[$];
  logic [DW-1:0] blk[$];
  bit            model_err = 1'b0;
  bit            model_busy = 1'b0;
  int            cyc = 0;
  int            beats = 0;
  int            beat_cyc[$];
  int            last_wr_cyc = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && !err && prev_stall) begin
      check("hold_valid", pvalid, 1'b1);
      check("hold_data", pdata, prev_data);
    end
    if (pvalid && pready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", pdata);
      end else begin
        check("stream_data", pdata, sb.pop_front());
      end
      beats <= beats + 1;
      beat_cyc.push_back(cyc);
    end
    prev_stall <= pvalid && !pready && rst_n;
    prev_data  <= pdata;
  end

  task automatic model_clear();
    model_err  = 1'b0;
    model_busy = 1'b0;
    blk.delete();
    sb.delete();
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d, input bit l);
    bit legal;
    legal = !model_err && !model_busy && (a == blk.size()) && (blk.size() < DEP);
    addr = a[AW-1:0]; wdata = d; last = l; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; last = 1'b0;
    last_wr_cyc = cyc;
    if (legal) begin
      blk.push_back(d);
      if (l) begin
        foreach (blk[i]) sb.push_back(blk[i]);
        blk.delete();
        model_busy = 1'b1;
      end
    end else begin
      model_err = 1'b1;
      blk.delete();
      sb.delete();
    end
    @(negedge clk);
    check("err_after_write", err, model_err);
    check("cont_after_write", cont, model_busy && !model_err);
    $display("write addr=%0d data=0x%0h last=%0d legal=%0d err=%0d", a, d, l, legal, err);
  endtask

  task automatic finish_block(input int mode);
    int k;
    bit ended;
    ended = 1'b0;
    for (k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      case (mode)
        0: pready = 1'b1;
        1: pready = (k % 3 == 0);
        default: pready = 1'($urandom_range(0, 1));
      endcase
      if (sb.size() == 0 && !pvalid) begin
        ended = 1'b1;
        break;
      end
    end
    if (!ended) begin
      checks++;
      fails++;
      $display("FAIL stream_timeout: %0d words still expected", sb.size());
    end
    @(negedge clk);
    check("wait_cont", cont, 1'b1);
    check("wait_valid", pvalid, 1'b0);
    check("wait_no_done", ddone, 1'b0);
    @(posedge clk); #1 pdone = 1'b1;
    @(posedge clk); #1 pdone = 1'b0;
    @(negedge clk);
    check("done_pulse", ddone, 1'b1);
    check("done_cont", cont, 1'b0);
    @(negedge clk);
    check("done_one_cycle", ddone, 1'b0);
    check("idle_cont", cont, 1'b0);
    model_busy = 1'b0;
    $display("block complete mode=%0d", mode);
  endtask

  task automatic run_block(input int n, input int mode, input logic [DW-1:0] base, input bit rnd);
    for (int i = 0; i < n; i++)
      write_word(i, rnd ? $urandom : base + DW'(i), i == n - 1);
    if (!model_err) finish_block(mode);
  endtask

  task automatic clear_err();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    model_clear();
    @(negedge clk);
    check("clr_err", err, 1'b0);
    check("clr_cont", cont, 1'b0);
    $display("error cleared");
  endtask

  task automatic s_write(input int a, input bit exp_err);
    s_addr = a[AW-1:0]; s_wdata = $urandom; s_last = 1'b0; s_we = 1'b1;
    @(posedge clk); #1 s_we = 1'b0;
    @(negedge clk);
    check("small_err", s_err, exp_err);
    $display("small write addr=%0d err=%0d", a, s_err);
  endtask

  initial begin
    int q0, b0, k;
    rst_n = 1'b0; addr = '0; we = 1'b0; last = 1'b0; wdata = '0; err_clr = 1'b0;
    pready = 1'b1; pdone = 1'b0;
    s_addr = '0; s_we = 1'b0; s_last = 1'b0; s_wdata = '0; s_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", pvalid, 1'b0);
    check("rst_data", pdata, '0);
    check("rst_cont", cont, 1'b0);
    check("rst_done", ddone, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;

    // Four-word block at full throughput.
    q0 = beat_cyc.size();
    write_word(0, 32'hA0, 0); write_word(1, 32'hA1, 0);
    write_word(2, 32'hA2, 0); write_word(3, 32'hA3, 1);
    b0 = last_wr_cyc;
    finish_block(0);
    check("first_beat_latency", beat_cyc[q0] - b0, 1);
    check("beat_spacing", beat_cyc[q0+3] - beat_cyc[q0], 3);

    run_block(1, 0, 32'h55, 0);
    run_block(3, 1, 32'h300, 0);

    // Out-of-sequence address: error, nothing streamed, then recovery.
    b0 = beats;
    write_word(0, 32'h10, 0); write_word(1, 32'h11, 0); write_word(3, 32'h13, 0);
    check("err_no_valid", pvalid, 1'b0);
    repeat (4) @(negedge clk);
    check("err_sticky", err, 1'b1);
    check("err_no_stream", beats, b0);
    clear_err();
    run_block(2, 0, 32'h700, 0);

    // Buffer full on the DEPTH=4 instance.
    for (int i = 0; i < 4; i++) s_write(i, 1'b0);
    s_write(4, 1'b1);
    check("small_no_valid", s_pvalid, 1'b0);

    // Write during STREAM.
    pready = 1'b0;
    write_word(0, 32'h21, 0); write_word(1, 32'h22, 0); write_word(2, 32'h23, 1);
    repeat (2) @(negedge clk);
    write_word(0, 32'h99, 0);
    check("stream_we_valid", pvalid, 1'b0);
    clear_err();

    // procc_done during FILL.
    write_word(0, 32'h31, 0); write_word(1, 32'h32, 0);
    pdone = 1'b1;
    @(posedge clk); #1 pdone = 1'b0;
    @(negedge clk);
    check("done_in_fill_err", err, 1'b1);
    clear_err();

    // Reset mid-stream after two of five words.
    pready = 1'b1;
    for (int i = 0; i < 5; i++) write_word(i, 32'hB0 + DW'(i), i == 4);
    b0 = beats;
    for (k = 0; k < 50 && beats - b0 < 2; k++) begin
      @(posedge clk); #1;
    end
    check("beats_before_reset", beats - b0, 2);
    rst_n = 1'b0;
    #1;
    check("arst_valid", pvalid, 1'b0);
    check("arst_data", pdata, '0);
    check("arst_cont", cont, 1'b0);
    check("arst_done", ddone, 1'b0);
    check("arst_err", err, 1'b0);
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    run_block(2, 0, 32'hC0, 0);

    for (int r = 0; r < 8; r++)
      run_block(int'($urandom_range(1, 10)), int'($urandom_range(0, 2)), '0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
